// File: rtl/ip4_rtl_rd_arb.sv
`default_nettype none
// ==========================================================================
// ip4_rtl_rd_arb : N-core AXI read-path arbiter (round-robin AR, ID-tag R routing)
// Revision 1.0
// ==========================================================================
module ip4_rtl_rd_arb #(
  parameter int NCORE    = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int ID_W     = 4,
  parameter int LEN_W    = 8,
  parameter int MAX_OUTS = 8,
  localparam int CW      = $clog2(NCORE),
  localparam int OW      = $clog2(MAX_OUTS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCORE-1:0]        s_arvalid,
  output logic [NCORE-1:0]        s_arready,
  input  logic [NCORE*ADDR_W-1:0] s_araddr,
  input  logic [NCORE*LEN_W-1:0]  s_arlen,
  input  logic [NCORE*ID_W-1:0]   s_arid,
  output logic [NCORE-1:0]        s_rvalid,
  input  logic [NCORE-1:0]        s_rready,
  output logic [DATA_W-1:0]       s_rdata,
  output logic [ID_W-1:0]         s_rid,
  output logic                    s_rlast,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic [LEN_W-1:0]        m_arlen,
  output logic [ID_W+CW-1:0]      m_arid,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [ID_W+CW-1:0]      m_rid,
  input  logic                    m_rlast,
  output logic [NCORE*OW-1:0]     outs_cnt,
  output logic                    err_orphan
);

  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTS);

  logic [CW-1:0]    rr_ptr;
  logic [OW-1:0]    cnt_r [NCORE];
  logic [NCORE-1:0] eligible;
  logic [NCORE-1:0] cnt_zero;
  logic [NCORE-1:0] inc;
  logic [NCORE-1:0] dec;
  logic             grant_vld;
  logic [CW-1:0]    grant_idx;
  logic             slot_free;
  logic             ar_fire;
  logic [CW-1:0]    r_tag;
  logic             tag_ok;
  logic             tag_zero;
  logic             r_fire;
  logic             r_orphan;

  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCORE) s = s - NCORE;
    return CW'(s);
  endfunction

  assign slot_free = ~m_arvalid | m_arready;
  assign ar_fire   = slot_free & grant_vld;

  // Walk the ring from the far end so the closest eligible core to rr_ptr wins.
  always_comb begin
    logic [CW-1:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    for (int k = NCORE - 1; k >= 0; k--) begin
      idx = wrap_add(rr_ptr, k);
      if (eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arid    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (ar_fire) begin
        m_arvalid <= 1'b1;
        m_araddr  <= s_araddr[grant_idx*ADDR_W +: ADDR_W];
        m_arlen   <= s_arlen[grant_idx*LEN_W +: LEN_W];
        m_arid    <= {grant_idx, s_arid[grant_idx*ID_W +: ID_W]};
        rr_ptr    <= wrap_add(grant_idx, 1);
      end else if (m_arready) begin
        m_arvalid <= 1'b0;
      end
    end
  end

  assign r_tag   = m_rid[ID_W+CW-1:ID_W];
  assign tag_ok  = (int'(r_tag) < NCORE);
  assign s_rdata = m_rdata;
  assign s_rid   = m_rid[ID_W-1:0];
  assign s_rlast = m_rlast;

  // Tags with no core behind them are swallowed so the master never stalls.
  always_comb begin
    m_rready = 1'b1;
    if (tag_ok) m_rready = s_rready[r_tag];
  end

  always_comb begin
    tag_zero = 1'b0;
    for (int i = 0; i < NCORE; i++) begin
      if (r_tag == CW'(i)) tag_zero = cnt_zero[i];
    end
  end

  assign r_fire   = m_rvalid & m_rready;
  assign r_orphan = r_fire & (~tag_ok | tag_zero);

  generate
    for (genvar i = 0; i < NCORE; i++) begin : g_core
      assign eligible[i]  = s_arvalid[i] & (cnt_r[i] < MAX_CNT);
      assign cnt_zero[i]  = (cnt_r[i] == '0);
      assign s_arready[i] = slot_free & grant_vld & (grant_idx == CW'(i));
      assign s_rvalid[i]  = m_rvalid & tag_ok & (r_tag == CW'(i));
      assign inc[i]       = ar_fire & (grant_idx == CW'(i));
      assign dec[i]       = r_fire & m_rlast & tag_ok & (r_tag == CW'(i)) & ~cnt_zero[i];
      assign outs_cnt[i*OW +: OW] = cnt_r[i];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_r[i] <= '0;
        end else begin
          case ({inc[i], dec[i]})
            2'b10:   cnt_r[i] <= cnt_r[i] + OW'(1);
            2'b01:   cnt_r[i] <= cnt_r[i] - OW'(1);
            default: cnt_r[i] <= cnt_r[i];
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_orphan <= 1'b0;
    else if (r_orphan) err_orphan <= 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_ip4_rtl_rd_arb.sv
`default_nettype none
// Directed bench for ip4_rtl_rd_arb: AR scoreboard plus per-step assertions.
module tb_ip4_rtl_rd_arb;
  localparam int NCORE = 4, ADDR_W = 32, DATA_W = 64, ID_W = 4, LEN_W = 8, MAX_OUTS = 2;
  localparam int CW = 2, OW = 2;

  logic                    clk, rst_n;
  logic [NCORE-1:0]        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NCORE*ADDR_W-1:0] s_araddr;
  logic [NCORE*LEN_W-1:0]  s_arlen;
  logic [NCORE*ID_W-1:0]   s_arid;
  logic [DATA_W-1:0]       s_rdata, m_rdata;
  logic [ID_W-1:0]         s_rid;
  logic                    s_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, err_orphan;
  logic [ADDR_W-1:0]       m_araddr;
  logic [LEN_W-1:0]        m_arlen;
  logic [ID_W+CW-1:0]      m_arid, m_rid;
  logic [NCORE*OW-1:0]     outs_cnt;

  typedef struct {
    logic [ID_W+CW-1:0] id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
  } ar_t;
  ar_t sb_q[$];

  int checks = 0;
  int errs   = 0;

  ip4_rtl_rd_arb #(.NCORE(NCORE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                   .LEN_W(LEN_W), .MAX_OUTS(MAX_OUTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arid(s_arid), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rid(s_rid), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arid(m_arid), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rid(m_rid), .m_rlast(m_rlast), .outs_cnt(outs_cnt), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] cnt(input int i);
    return outs_cnt[i*OW +: OW];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    s_araddr[i*ADDR_W +: ADDR_W] = a;
    s_arlen[i*LEN_W +: LEN_W]    = l;
    s_arid[i*ID_W +: ID_W]       = id;
  endtask

  task automatic r_beat(input int core, input logic [3:0] id, input logic last);
    m_rvalid = 1'b1;
    m_rid    = {2'(core), id};
    m_rlast  = last;
  endtask

  task automatic r_idle;
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  // Drain one single-beat burst per listed core with all cores ready.
  task automatic drain(input int core);
    s_rready = 4'hF;
    r_beat(core, 4'h0, 1'b1);
    #1;
    chk("drain_rvalid", 64'(s_rvalid), 64'(4'b1 << core));
    tick;
    r_idle;
  endtask

  // AR scoreboard: requests accepted on the slave side must leave the master side in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_arvalid && m_arready) begin
        checks++;
        assert (sb_q.size() > 0) else begin
          errs++;
          $error("FAIL sb_underflow observed=%0h expected=queued_entry", m_arid);
        end
        if (sb_q.size() > 0) begin
          ar_t e;
          e = sb_q.pop_front();
          chk("sb_arid", 64'(m_arid), 64'(e.id));
          chk("sb_araddr", 64'(m_araddr), 64'(e.addr));
          chk("sb_arlen", 64'(m_arlen), 64'(e.len));
        end
      end
      for (int i = 0; i < NCORE; i++) begin
        if (s_arvalid[i] && s_arready[i])
          sb_q.push_back('{id: {2'(i), s_arid[i*ID_W +: ID_W]},
                           addr: s_araddr[i*ADDR_W +: ADDR_W],
                           len: s_arlen[i*LEN_W +: LEN_W]});
      end
    end
  end

  initial begin
    rst_n = 1'b1; s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arid = '0;
    s_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rid = '0; m_rlast = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_m_arid", 64'(m_arid), 64'd0);
    chk("rst_outs_cnt", 64'(outs_cnt), 64'd0);
    chk("rst_err_orphan", 64'(err_orphan), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    tick;

    // T1: single core2 request and its 4-beat burst
    m_arready = 1'b1;
    set_req(2, 32'h100, 8'd3, 4'd5);
    s_arvalid = 4'b0100;
    #1 chk("t1_arready", 64'(s_arready), 64'b0100);
    tick;
    s_arvalid = '0;
    #1;
    chk("t1_m_arvalid", 64'(m_arvalid), 64'd1);
    chk("t1_m_arid", 64'(m_arid), 64'h25);
    chk("t1_cnt2", 64'(cnt(2)), 64'd1);
    tick;
    s_rready = 4'b0100;
    for (int b = 0; b < 4; b++) begin
      r_beat(2, 4'd5, b == 3);
      m_rdata = 64'hA5A5_0000_0000_0000 + 64'(b);
      #1;
      chk("t1_s_rvalid", 64'(s_rvalid), 64'b0100);
      chk("t1_s_rid", 64'(s_rid), 64'd5);
      chk("t1_m_rready", 64'(m_rready), 64'd1);
      chk("t1_s_rdata", s_rdata, 64'hA5A5_0000_0000_0000 + 64'(b));
      tick;
    end
    r_idle;
    #1;
    chk("t1_cnt2_done", 64'(cnt(2)), 64'd0);
    chk("t1_no_orphan", 64'(err_orphan), 64'd0);

    // T2: all cores request; rr_ptr now points at core3
    for (int i = 0; i < NCORE; i++) set_req(i, 32'h1000 + 32'(i), 8'(i), 4'(i + 1));
    s_arvalid = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t2_grant", 64'(s_arready), 64'(4'b1 << ((3 + k) % 4)));
      tick;
    end
    chk("t2_all_full", 64'(s_arready), 64'd0);
    for (int i = 0; i < NCORE; i++) chk("t2_cnt", 64'(cnt(i)), 64'd2);
    s_arvalid = '0;
    tick;
    for (int k = 0; k < 8; k++) drain(k % 4);
    #1 chk("t2_cnt_drained", 64'(outs_cnt), 64'd0);

    // T3: core0 capped at MAX_OUTS while core1 still granted
    set_req(0, 32'h2000, 8'd0, 4'd7);
    set_req(1, 32'h2100, 8'd1, 4'd8);
    s_arvalid = 4'b0001;
    #1 chk("t3_g1", 64'(s_arready), 64'b0001);
    tick;
    chk("t3_g2", 64'(s_arready), 64'b0001);
    tick;
    chk("t3_held", 64'(s_arready), 64'b0000);
    s_arvalid = 4'b0011;
    #1 chk("t3_core1", 64'(s_arready), 64'b0010);
    tick;
    s_arvalid = 4'b0001;
    s_rready  = 4'b0001;
    r_beat(0, 4'd7, 1'b1);
    #1;
    chk("t3_still_held", 64'(s_arready), 64'b0000);
    chk("t3_m_rready", 64'(m_rready), 64'd1);
    tick;
    r_idle;
    #1;
    chk("t3_cnt0_dec", 64'(cnt(0)), 64'd1);
    chk("t3_regrant", 64'(s_arready), 64'b0001);
    tick;
    s_arvalid = '0;
    #1 chk("t3_cnt0", 64'(cnt(0)), 64'd2);
    tick;
    drain(0); drain(0); drain(1);
    #1 chk("t3_cnt_drained", 64'(outs_cnt), 64'd0);

    // T4: master back-pressure holds the slot, then reload on accept
    m_arready = 1'b0;
    set_req(1, 32'hAAAA_0000, 8'd4, 4'd3);
    s_arvalid = 4'b0010;
    #1 chk("t4_first", 64'(s_arready), 64'b0010);
    tick;
    set_req(1, 32'hBBBB_0000, 8'd6, 4'd9);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_addr", 64'(m_araddr), 64'hAAAA_0000);
      chk("t4_hold_valid", 64'(m_arvalid), 64'd1);
      chk("t4_no_ready", 64'(s_arready), 64'd0);
      tick;
    end
    m_arready = 1'b1;
    #1 chk("t4_reload", 64'(s_arready), 64'b0010);
    tick;
    s_arvalid = '0;
    #1;
    chk("t4_new_addr", 64'(m_araddr), 64'hBBBB_0000);
    chk("t4_cnt1", 64'(cnt(1)), 64'd2);
    tick;
    drain(1); drain(1);

    // T5: core3 increment and decrement in the same cycle
    set_req(3, 32'h3000, 8'd2, 4'd1);
    s_arvalid = 4'b1000;
    tick;
    s_arvalid = '0;
    #1 chk("t5_cnt3_one", 64'(cnt(3)), 64'd1);
    tick;
    s_arvalid = 4'b1000;
    s_rready  = 4'b1000;
    r_beat(3, 4'd1, 1'b1);
    #1 chk("t5_grant", 64'(s_arready), 64'b1000);
    tick;
    s_arvalid = '0;
    r_idle;
    #1 chk("t5_cnt3_same", 64'(cnt(3)), 64'd1);
    tick;
    drain(3);
    #1 chk("t5_cnt_drained", 64'(outs_cnt), 64'd0);

    // T6: orphan beat, sticky flag, async reset mid-burst
    s_rready = 4'b0010;
    r_beat(1, 4'd2, 1'b1);
    #1 chk("t6_orphan_route", 64'(s_rvalid), 64'b0010);
    tick;
    r_idle;
    #1;
    chk("t6_err_set", 64'(err_orphan), 64'd1);
    chk("t6_cnt1_zero", 64'(cnt(1)), 64'd0);
    tick; tick;
    chk("t6_err_sticky", 64'(err_orphan), 64'd1);
    m_arready = 1'b0;
    set_req(0, 32'h4000, 8'd1, 4'd4);
    s_arvalid = 4'b0001;
    tick;
    s_arvalid = '0;
    s_rready  = 4'b0001;
    r_beat(0, 4'd4, 1'b0);
    #1 chk("t6_pre_rst_valid", 64'(m_arvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("t6_rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("t6_rst_cnt", 64'(outs_cnt), 64'd0);
    chk("t6_rst_err", 64'(err_orphan), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    m_arready = 1'b1;
    m_rlast = 1'b1;
    tick;
    r_idle;
    #1;
    chk("t6_inflight_orphan", 64'(err_orphan), 64'd1);
    chk("t6_cnt0_held", 64'(cnt(0)), 64'd0);
    tick;
    chk("sb_empty_end", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
`default_nettype wire
